// File: rtl/adc_sample_conditioner_if.sv
// Output stream from the ADC sample conditioner to the audio path.
// Handshake: the producer raises out_valid with out_data; a transfer happens
// on every rising clock edge where out_valid && out_ready are both high.
interface adc_sample_conditioner_if;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;

    // Producer side (the conditioner)
    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    // Consumer side (the audio path)
    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/adc_sample_conditioner.sv
// ADC sample conditioner: offset-binary to two's complement, optional
// leaky-integrator DC removal with saturation, accumulate-and-dump
// decimation, and a valid/ready output with a sticky overrun flag.
module adc_sample_conditioner #(
    parameter int DC_SHIFT = 8,   // DC tracker time constant 2^DC_SHIFT, 4..12
    parameter int LOG2_DEC = 2    // decimation factor 2^LOG2_DEC, 0..4
) (
    input  logic                            sclk,
    input  logic                            rst,
    input  logic                            sample_tick,
    input  logic [11:0]                     din,
    input  logic                            dc_en,
    input  logic                            clr_ovr,
    adc_sample_conditioner_if.master        aout,
    output logic                            overrun
);

    localparam int DW = 12 + DC_SHIFT + 1;
    localparam int SW = 12 + LOG2_DEC;
    localparam int CW = (LOG2_DEC > 0) ? LOG2_DEC : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((1 << LOG2_DEC) - 1);

    logic                  tick_d_q;
    logic                  a_vld_q;
    logic signed [11:0]    x_q;
    logic signed [DW-1:0]  dc_acc_q, dc_acc_d;
    logic signed [SW-1:0]  sum_q, sum_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  done_q;
    logic                  out_valid_q;
    logic [11:0]           out_data_q;
    logic                  overrun_q, overrun_d;

    logic                  accept;
    logic signed [11:0]    dc;
    logic signed [11:0]    dc_sub;
    logic signed [12:0]    diff;
    logic signed [12:0]    trk;
    logic signed [11:0]    y;
    logic signed [SW-1:0]  sum_base;
    logic                  ovr_set;

    // A tick counts only on its rising edge; tick_d_q resets high so a tick
    // already high when reset releases is ignored.
    assign accept = sample_tick & ~tick_d_q;

    // Stage B datapath: DC estimate, saturating subtract, tracker update,
    // group accumulation and group counter.
    always_comb begin
        dc       = dc_acc_q[DC_SHIFT +: 12];
        dc_sub   = dc_en ? dc : 12'sd0;
        diff     = {x_q[11], x_q} - {dc_sub[11], dc_sub};
        if (diff[12] != diff[11]) begin
            y = diff[12] ? 12'sh800 : 12'sh7FF;
        end else begin
            y = diff[11:0];
        end
        trk      = {x_q[11], x_q} - {dc[11], dc};
        dc_acc_d = dc_acc_q + DW'(trk);
        sum_base = (cnt_q == '0) ? '0 : sum_q;
        sum_d    = sum_base + SW'(y);
        cnt_d    = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    end

    // Overrun is set when a new result replaces an unconsumed one; set wins
    // over a simultaneous clear.
    always_comb begin
        ovr_set   = done_q && out_valid_q && !aout.out_ready;
        overrun_d = ovr_set | (overrun_q & ~clr_ovr);
    end

    // Stage A: capture and convert the sample on an accepting edge.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            tick_d_q <= 1'b1;
            a_vld_q  <= 1'b0;
            x_q      <= '0;
        end else begin
            tick_d_q <= sample_tick;
            a_vld_q  <= accept;
            if (accept) begin
                x_q <= {~din[11], din[10:0]};
            end
        end
    end

    // Stage B: DC tracker, decimation accumulator and group-complete strobe.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            dc_acc_q <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= a_vld_q && (cnt_q == CNT_LAST);
            if (a_vld_q) begin
                dc_acc_q <= dc_acc_d;
                sum_q    <= sum_d;
                cnt_q    <= cnt_d;
            end
        end
    end

    // Output stage: load the averaged result, retire it on handshake.
    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
            if (done_q) begin
                out_valid_q <= 1'b1;
                out_data_q  <= sum_q[LOG2_DEC +: 12];
            end else if (out_valid_q && aout.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign aout.out_valid = out_valid_q;
    assign aout.out_data  = out_data_q;
    assign overrun        = overrun_q;

endmodule
